// File: rtl/cpu_ctrl_pkg.sv
// Shared types and instruction-field constants for the multicycle sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam int INSTR_WIDTH = 16;

  // Field slices within the 16-bit instruction word
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int FN_HI  = 1;
  localparam int FN_LO  = 0;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_ALU_R      = 4'h1;
  localparam logic [3:0] OP_ALU_I      = 4'b0100;  // 4'b01xx family
  localparam logic [3:0] OP_ALU_I_MASK = 4'b1100;
  localparam logic [3:0] OP_BZ         = 4'h8;
  localparam logic [3:0] OP_BNZ        = 4'h9;
  localparam logic [3:0] OP_JMP        = 4'hA;
  localparam logic [3:0] OP_HALT       = 4'hF;

  function automatic logic is_alu_i_op(input logic [3:0] op);
    return (op & OP_ALU_I_MASK) == OP_ALU_I;
  endfunction

endpackage

// File: rtl/datapath_sequencer_instr_decoder.sv
// Decodes the latched instruction into datapath control fields and op classes.
// Latency: purely combinational.
// Backpressure: none; outputs follow ir continuously.
module instr_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int RADDR_WIDTH = 4
) (
  input  logic [15:0]            ir,
  output logic [RADDR_WIDTH-1:0] ra1,
  output logic [RADDR_WIDTH-1:0] ra2,
  output logic [RADDR_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0]  immediate,
  output logic [1:0]             alu_control,
  output logic                   alu_src,
  output logic                   is_alu,
  output logic                   is_branch,
  output logic                   is_halt,
  output logic [7:0]             target
);

  logic [3:0] op;
  assign op     = ir[OP_HI:OP_LO];
  assign target = ir[IMM_HI:IMM_LO];

  // Field decode; anything an opcode does not use stays 0
  always_comb begin
    ra1         = '0;
    ra2         = '0;
    wa          = '0;
    immediate   = '0;
    alu_control = '0;
    alu_src     = 1'b0;
    is_alu      = 1'b0;
    is_branch   = 1'b0;
    is_halt     = 1'b0;
    if (op == OP_ALU_R) begin
      ra1         = RADDR_WIDTH'(ir[RD_HI:RD_LO]);
      wa          = RADDR_WIDTH'(ir[RD_HI:RD_LO]);
      ra2         = RADDR_WIDTH'(ir[RS_HI:RS_LO]);
      alu_control = ir[FN_HI:FN_LO];
      is_alu      = 1'b1;
    end else if (is_alu_i_op(op)) begin
      ra1         = RADDR_WIDTH'(ir[RD_HI:RD_LO]);
      wa          = RADDR_WIDTH'(ir[RD_HI:RD_LO]);
      immediate   = DATA_WIDTH'(ir[IMM_HI:IMM_LO]);
      alu_control = op[1:0];
      alu_src     = 1'b1;
      is_alu      = 1'b1;
    end else if (op == OP_BZ || op == OP_BNZ || op == OP_JMP) begin
      is_branch = 1'b1;
    end else if (op == OP_HALT) begin
      is_halt = 1'b1;
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multicycle controller: fetches from a sync ROM, sequences FETCH/DECODE/EXECUTE.
// Latency: 3 cycles per instruction; first write strobe 3 cycles after run seen in IDLE.
// Backpressure: run gates progress, sampled only in IDLE and at the end of EXECUTE.
module datapath_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int RADDR_WIDTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic [PC_WIDTH-1:0]    instr_addr,
  input  logic [15:0]            instr_data,
  output logic [RADDR_WIDTH-1:0] RA1,
  output logic [RADDR_WIDTH-1:0] RA2,
  output logic [RADDR_WIDTH-1:0] WA,
  output logic [DATA_WIDTH-1:0]  immediate,
  output logic [1:0]             ALUControl,
  output logic                   ALUSrc,
  output logic                   write_enable,
  input  logic                   Zero,
  output logic                   halted,
  output logic                   busy
);

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [15:0]         ir;
  logic                zflag;
  logic                is_alu, is_branch, is_halt, taken;
  logic [7:0]          target;
  logic [3:0]          op;

  instr_decoder #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RADDR_WIDTH (RADDR_WIDTH)
  ) u_dec (
    .ir          (ir),
    .ra1         (RA1),
    .ra2         (RA2),
    .wa          (WA),
    .immediate   (immediate),
    .alu_control (ALUControl),
    .alu_src     (ALUSrc),
    .is_alu      (is_alu),
    .is_branch   (is_branch),
    .is_halt     (is_halt),
    .target      (target)
  );

  assign op           = ir[OP_HI:OP_LO];
  assign instr_addr   = pc;
  assign write_enable = (state == EXECUTE) && is_alu;
  assign halted       = (state == HALT);
  assign busy         = (state == FETCH) || (state == DECODE) || (state == EXECUTE);

  // Branch resolution against the flag left by the last completed ALU op
  always_comb begin
    taken = 1'b0;
    if (is_branch) begin
      case (op)
        OP_BZ:   taken = zflag;
        OP_BNZ:  taken = !zflag;
        OP_JMP:  taken = 1'b1;
        default: taken = 1'b0;
      endcase
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH:   state_nxt = DECODE;
      DECODE:  state_nxt = EXECUTE;
      EXECUTE: begin
        if (is_halt) begin
          state_nxt = HALT;
        end else begin
          pc_nxt    = taken ? PC_WIDTH'(target) : pc + PC_WIDTH'(1);
          state_nxt = run ? FETCH : IDLE;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // State, PC, instruction register and zero flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= PC_WIDTH'(RESET_PC);
      ir    <= '0;
      zflag <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == DECODE)
        ir <= instr_data;
      if (state == EXECUTE && is_alu)
        zflag <= Zero;
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a behavioural sync ROM.
// Latency: checks are taken on the falling edge, half a cycle after each update.
// Backpressure: run is driven by the stimulus to exercise idle/continue paths.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, Zero;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic [3:0]  RA1, RA2, WA;
  logic [7:0]  immediate;
  logic [1:0]  ALUControl;
  logic        ALUSrc, write_enable, halted, busy;

  logic [15:0] rom [256];
  int          n_tests = 0;
  int          n_fail  = 0;

  datapath_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .immediate    (immediate),
    .ALUControl   (ALUControl),
    .ALUSrc       (ALUSrc),
    .write_enable (write_enable),
    .Zero         (Zero),
    .halted       (halted),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM: data one cycle after the address
  always @(posedge clk) instr_data <= rom[instr_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // From IDLE: raise run, advance to EXECUTE, then drop run so the op ends in IDLE
  task automatic go_execute();
    run = 1'b1;
    repeat (3) @(negedge clk);
    run = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h430A;  // ALU_I r3, 0x0A, ctl 00
    rom[8'h01] = 16'h1213;  // ALU_R r2, r1, fn 11
    rom[8'h02] = 16'h8020;  // BZ 0x20
    rom[8'h03] = 16'h5123;  // ALU_I r1, 0x23, ctl 01
    rom[8'h05] = 16'h9030;  // BNZ 0x30
    rom[8'h20] = 16'h4000;  // ALU_I r0, 0x00
    rom[8'h21] = 16'h8040;  // BZ 0x40
    rom[8'h22] = 16'hA005;  // JMP 0x05
    rom[8'h30] = 16'hA0FF;  // JMP 0xFF
    rom[8'hFF] = 16'h0000;  // NOP at top of address space

    reset = 1'b1; run = 1'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_addr", instr_addr, 0);
    check("rst_we", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_fields", {RA1, RA2, WA, immediate, ALUControl, ALUSrc}, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
    end
    check("idle_addr", instr_addr, 0);

    // ALU_I at 0
    run = 1'b1;
    @(negedge clk);
    check("fetch_busy", busy, 1);
    check("fetch_we", write_enable, 0);
    repeat (2) @(negedge clk);
    run = 1'b0;
    check("alui_ra1", RA1, 3);
    check("alui_wa", WA, 3);
    check("alui_ra2", RA2, 0);
    check("alui_imm", immediate, 8'h0A);
    check("alui_src", ALUSrc, 1);
    check("alui_ctl", ALUControl, 0);
    check("alui_we", write_enable, 1);
    @(negedge clk);
    check("alui_we_off", write_enable, 0);
    check("alui_next", instr_addr, 1);
    check("alui_idle", busy, 0);

    // ALU_R at 1, sets zflag
    go_execute();
    Zero = 1'b1;
    check("alur_ra1", RA1, 2);
    check("alur_wa", WA, 2);
    check("alur_ra2", RA2, 1);
    check("alur_imm", immediate, 0);
    check("alur_src", ALUSrc, 0);
    check("alur_ctl", ALUControl, 3);
    check("alur_we", write_enable, 1);
    @(negedge clk);
    Zero = 1'b0;
    check("alur_we_off", write_enable, 0);
    check("alur_next", instr_addr, 2);

    // BZ taken on zflag=1 (Zero during a branch must not matter)
    go_execute();
    check("bz_we", write_enable, 0);
    @(negedge clk);
    check("bz_taken", instr_addr, 8'h20);

    // ALU_I with Zero=0 clears zflag, then BZ not taken
    go_execute();
    @(negedge clk);
    check("alu20_next", instr_addr, 8'h21);
    go_execute();
    @(negedge clk);
    check("bz_not_taken", instr_addr, 8'h22);

    // JMP always, BNZ taken on zflag=0
    go_execute();
    @(negedge clk);
    check("jmp", instr_addr, 8'h05);
    go_execute();
    @(negedge clk);
    check("bnz_taken", instr_addr, 8'h30);

    // Wrap: JMP 0xFF, NOP at 0xFF -> 0x00
    go_execute();
    @(negedge clk);
    check("jmp_ff", instr_addr, 8'hFF);
    go_execute();
    @(negedge clk);
    check("wrap", instr_addr, 8'h00);

    // Drop run during DECODE: instruction completes, then IDLE
    run = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("drop_we", write_enable, 1);
    @(negedge clk);
    check("drop_idle", busy, 0);
    check("drop_next", instr_addr, 1);

    // Continuous run: ALU_R (Zero=0) then BZ not taken, CPI 3
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("cont_we1", write_enable, 1);
    @(negedge clk);
    check("cont_fetch_busy", busy, 1);
    check("cont_fetch_we", write_enable, 0);
    check("cont_addr", instr_addr, 2);
    repeat (2) @(negedge clk);
    run = 1'b0;
    check("cont_bz_we", write_enable, 0);
    @(negedge clk);
    check("cont_bz_next", instr_addr, 3);
    check("cont_idle", busy, 0);

    // Reset during EXECUTE aborts
    go_execute();
    check("abort_ctl", ALUControl, 1);
    check("abort_we_pre", write_enable, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_we", write_enable, 0);
    check("abort_pc", instr_addr, 0);
    check("abort_busy", busy, 0);
    check("abort_ra1", RA1, 0);

    // HALT at 0 freezes everything
    rom[8'h00] = 16'hF000;
    go_execute();
    check("halt_exec_we", write_enable, 0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      check("halted", halted, 1);
      check("halt_busy", busy, 0);
      check("halt_we", write_enable, 0);
      check("halt_pc", instr_addr, 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multicycle controller that drives the register-file/ALU datapath: the control-side counterpart that produces RA1, RA2, WA, immediate, ALUControl, ALUSrc and write_enable, and consumes Zero.
- Fetches 16-bit instructions from an external synchronous instruction ROM using its own PC.
- Decodes each instruction and sequences it over 3 cycles: FETCH, DECODE, EXECUTE.
- Branches on a latched Zero flag.
- Sits between the instruction ROM and the datapath at CPU top level.

Parameters:
PC_WIDTH, 8, instruction address width; PC wraps modulo 2^PC_WIDTH
DATA_WIDTH, 8, immediate width; must equal the datapath width
RADDR_WIDTH, 4, register address width (16 registers)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on its rising edge
reset  input  1  synchronous, active-high reset
run  input  1  start/continue execution; sampled in IDLE and at the end of EXECUTE
instr_addr  output  PC_WIDTH  ROM address, equal to PC
instr_data  input  16  ROM data; valid one cycle after instr_addr
RA1  output  RADDR_WIDTH  datapath read address 1
RA2  output  RADDR_WIDTH  datapath read address 2
WA  output  RADDR_WIDTH  datapath write address
immediate  output  DATA_WIDTH  immediate operand
ALUControl  output  2  ALU function, passed through from the instruction
ALUSrc  output  1  1 selects immediate as operand B, 0 selects the RA2 register
write_enable  output  1  register write strobe
Zero  input  1  ALU zero result from the datapath, combinational during EXECUTE
halted  output  1  high while in HALT
busy  output  1  high in FETCH, DECODE and EXECUTE

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high.
- Reset loads:
  - PC = RESET_PC, ir = 16'h0000 (NOP), zflag = 0, state = IDLE.
  - All outputs are 0 from the first edge after reset. instr_addr = RESET_PC.
- Instruction fields: op = ir[15:12], rd = ir[11:8], rs = ir[7:4], imm = ir[7:0], fn = ir[1:0].
- Opcodes:
  - 0x0 NOP
  - 0x1 ALU_R: RA1 = WA = rd, RA2 = rs, ALUSrc = 0, ALUControl = fn, writes the register file
  - 0x4..0x7 ALU_I: RA1 = WA = rd, immediate = imm, ALUSrc = 1, ALUControl = op[1:0], writes the register file
  - 0x8 BZ: PC = imm if zflag = 1
  - 0x9 BNZ: PC = imm if zflag = 0
  - 0xA JMP: PC = imm unconditionally
  - 0xF HALT
  - Any other opcode executes as NOP.
- Datapath outputs (RA1, RA2, WA, immediate, ALUControl, ALUSrc) are decoded combinationally from ir in every state. A field an opcode does not use is driven to 0.
- write_enable = 1 only in EXECUTE with an ALU_R or ALU_I op: exactly one cycle per ALU instruction, 0 everywhere else.
- State machine:
  - IDLE: if run = 1, go to FETCH.
  - FETCH: instr_addr = PC; go to DECODE.
  - DECODE: ir <= instr_data; go to EXECUTE.
  - EXECUTE:
    - ALU ops: zflag <= Zero at the clock edge, together with the register write.
    - PC update: branch target if the branch is taken; otherwise PC + 1, wrapping 255 -> 0.
    - Next state: HALT if op = 0xF (PC not incremented); else FETCH if run = 1; else IDLE with PC retained.
  - HALT: stays in HALT until reset; halted = 1.
- Branch timing: branches use zflag from the most recent completed ALU instruction; non-ALU instructions leave zflag unchanged.
- CPI = 3. The first write_enable occurs 3 cycles after run is sampled high in IDLE.
- Reset during EXECUTE aborts the current instruction. write_enable is 0 from that edge onward. The register write on that same edge is the datapath's concern.
- run changes outside IDLE and the end of EXECUTE are ignored.

Decomposition:
- Package cpu_ctrl_pkg:
  - state_t enum {IDLE, FETCH, DECODE, EXECUTE, HALT}
  - opcode localparams OP_NOP, OP_ALU_R, OP_ALU_I (4'b01xx), OP_BZ, OP_BNZ, OP_JMP, OP_HALT
  - field-slice constants
- One combinational sub-module, instr_decoder: takes ir and produces the datapath control fields plus is_alu, is_branch and is_halt.
- The FSM, PC and zflag stay in the top module.

Test Plan:
- Reset/idle: hold reset 2 cycles, run = 0 -> all outputs 0, instr_addr = 0, busy = 0, state stays IDLE for 10 cycles.
- ALU_I: ROM[0] = 16'h430A, run = 1 -> in EXECUTE RA1 = WA = 3, immediate = 8'h0A, ALUSrc = 1, ALUControl = 2'b00, write_enable = 1 for exactly one cycle; next instr_addr = 1.
- ALU_R: ROM[0] = 16'h1213 -> RA1 = WA = 2, RA2 = 1, ALUSrc = 0, ALUControl = 2'b11, one write_enable pulse.
- Branch: ALU op with Zero = 1 in EXECUTE, then BZ 8'h20 -> PC = 0x20. Repeat with Zero = 0 -> PC = previous + 1. Also check JMP 0x05 is always taken.
- Boundaries: NOP at address 0xFF -> PC wraps to 0x00. HALT -> halted = 1, write_enable = 0, PC frozen across 20 cycles regardless of run.
- Mid-operation: drop run during DECODE -> instruction completes, then IDLE with PC = next. Assert reset in EXECUTE -> write_enable = 0 and PC = 0 after that edge.
